// File: rtl/ddsm_fcw_ramp_ctrl.sv
// FCW ramp sequencer for the MASH 1-1-1 DDSM input: steps x_o toward a commanded target, then settles and reports lock.
// Optional macro DDSM_CTRL_RETARGET_EN: accept new commands while busy (retarget mid-ramp/settle).
module ddsm_fcw_ramp_ctrl #(
    parameter int WIDTH      = 9,
    parameter int DWELL_W    = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [WIDTH-1:0]   cmd_target_i,
    input  logic [WIDTH-1:0]   cmd_step_i,
    input  logic [DWELL_W-1:0] cmd_dwell_i,
    output logic [WIDTH-1:0]   x_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               locked_o
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               done_q, done_d;
    logic               locked_q, locked_d;

    logic               accept;
    logic               going_up;
    logic [WIDTH:0]     diff;
    logic               last_step;

`ifdef DDSM_CTRL_RETARGET_EN
    assign cmd_ready_o = 1'b1;
`else
    assign cmd_ready_o = (state_q == ST_IDLE);
`endif

    assign accept = cmd_valid_i && cmd_ready_o;

    // Distance to target is taken one bit wider so the step comparison can never wrap.
    assign going_up  = (target_q > x_q);
    assign diff      = going_up ? ({1'b0, target_q} - {1'b0, x_q})
                                : ({1'b0, x_q} - {1'b0, target_q});
    assign last_step = (step_q == '0) || (diff <= {1'b0, step_q});

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        target_d     = target_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        dwell_cnt_d  = dwell_cnt_q;
        settle_cnt_d = settle_cnt_q;
        done_d       = 1'b0;
        locked_d     = locked_q;

        case (state_q)
            ST_RAMP: begin
                if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - 1'b1;
                end else if (last_step) begin
                    x_d          = target_q;
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end else begin
                    x_d         = going_up ? (x_q + step_q) : (x_q - step_q);
                    dwell_cnt_d = dwell_q;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    locked_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An accepted command overrides any in-flight progress; x_o is held on the accepting edge.
        if (accept) begin
            target_d = cmd_target_i;
            step_d   = cmd_step_i;
            dwell_d  = cmd_dwell_i;
            x_d      = x_q;
            done_d   = 1'b0;
            locked_d = 1'b0;
            if (cmd_target_i == x_q) begin
                state_d      = ST_SETTLE;
                settle_cnt_d = SETTLE_LOAD;
            end else begin
                state_d     = ST_RAMP;
                dwell_cnt_d = cmd_dwell_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            target_q     <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            settle_cnt_q <= '0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            target_q     <= target_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            dwell_cnt_q  <= dwell_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            done_q       <= done_d;
            locked_q     <= locked_d;
        end
    end

    assign x_o      = x_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign locked_o = locked_q;

endmodule
